regfile_dump_reader: RTL and testbench
======================================

# regfile_dump_reader

Debug read-out engine for the single-cycle CPU register file. On a start pulse it freezes architectural writes and walks the register file's second read port from the first to the last register. It streams each (index, value) pair out over a valid/ready handshake to the host/debug link, then releases the freeze. It sits beside the datapath, sharing the register file's combinational read port through a debug mux, and its `freeze` output gates the register file's write enable.

## Interface
- `NUM_REGS`, default 32: number of architectural registers.
- `ADDR_W`, default 5: register index width; must satisfy 2^ADDR_W ≥ NUM_REGS.
- `DATA_W`, default 32: register data width.
- `SKIP_ZERO`, default 1: 1 starts the walk at index 1, because r0 is hard-wired to 0; 0 starts at index 0.
- `CLK` input, 1 bit: single clock; all state updates on the rising edge.
- `RST` input, 1 bit: asynchronous, active-high reset.
- `start` input, 1 bit: dump request; sampled only in IDLE.
- `rd_addr` output, ADDR_W bits: register file read address, driven from the index register.
- `rd_data` input, DATA_W bits: combinational register file read data for `rd_addr`.
- `freeze` output, 1 bit: high while a dump is in progress; upstream forces register file WE low.
- `out_valid` output, 1 bit: the output word is valid.
- `out_ready` input, 1 bit: the consumer accepts the word.
- `out_addr` output, ADDR_W bits: register index of the output word.
- `out_data` output, DATA_W bits: register value.
- `out_last` output, 1 bit: qualifies the final word (index NUM_REGS-1).
- `busy` output, 1 bit: state is not IDLE.
- `done` output, 1 bit: one-cycle pulse at the end of the dump.

## Operation
- FSM states: IDLE, FREEZE, FETCH, SEND, DONE.
- **IDLE**: `rd_addr`=0 and `freeze`=0. When `start`=1 at the clock edge, load idx = (SKIP_ZERO ? 1 : 0) and go to FREEZE.
- **FREEZE**: lasts one cycle with `freeze`=1. The register file writes on the falling edge, so a write launched in the cycle `start` was sampled completes before the first read. Go to FETCH.
- **FETCH**: `rd_addr`=idx. At the edge, capture `out_data`←`rd_data`, `out_addr`←idx, `out_last`←(idx==NUM_REGS-1), and set `out_valid`←1. Go to SEND.
- **SEND**: hold `out_valid`, `out_addr`, `out_data` and `out_last` stable until `out_valid`&&`out_ready` at an edge. On that transfer:
  - if `out_last`: clear `out_valid` and go to DONE;
  - otherwise: idx←idx+1, clear `out_valid`, go to FETCH.
- **DONE**: `done`=1 and `freeze`=1 for one cycle, then go to IDLE. `freeze` drops in IDLE.
- `start` is ignored in every state except IDLE, and is not queued.
- `freeze`=1 in FREEZE, FETCH, SEND and DONE. `busy`=1 in every state except IDLE.
- `out_valid` is never withdrawn before a transfer. `out_ready` may be held high continuously.
- idx never exceeds NUM_REGS-1, so there is no wrap.
- Reset mid-dump: all outputs drop immediately and the FSM returns to IDLE. The partial stream is abandoned, with no `done` and no `out_last`.

## Timing
- Reset values: `out_valid`=0, `out_last`=0, `out_addr`=0, `out_data`=0, `rd_addr`=0, `freeze`=0, `busy`=0, `done`=0; state=IDLE.
- Edge 0 samples `start`. The first `out_valid` rises after edge 2 (FREEZE, then FETCH).
- With `out_ready` held at 1, each word takes 2 cycles (FETCH + SEND).
- Total dump cycles from the `start` edge to return to IDLE: 1 + 2·W + 1, where W = NUM_REGS − (SKIP_ZERO ? 1 : 0). With the defaults W=31, giving 64 cycles.
- `done` is high for exactly one cycle, in the cycle after the last transfer edge.
- `rd_data` is combinational relative to `rd_addr` and is sampled only at the FETCH edge.

## Structure
- A shared package holds:
  - the FSM state enumeration (IDLE/FREEZE/FETCH/SEND/DONE);
  - default constants NUM_REGS=32, ADDR_W=5, DATA_W=32.
- Single module with no sub-module. The index counter and output register are inline.
- The debug read mux and the WE gating live in the CPU top level, not in this block.

## Test plan
- **Full dump:** preload r_i = 0x0000_0100+i for i=1..31, pulse `start`, hold `out_ready`=1.
  - Expect 31 transfers, addr 1..31 with data 0x101..0x11F.
  - `out_last` only on addr 31; `done` at cycle 63; `busy` falls at cycle 64.
- **Backpressure:** drive `out_ready` low for 5 cycles on word 7.
  - `out_valid`, `out_addr`=7 and `out_data`=0x107 stay stable throughout.
  - No word is skipped or duplicated.
- **Freeze/race:** in the same cycle as `start`, the CPU writes r3=0xDEAD_BEEF; attempt a write to r4=0x1234 while `freeze`=1.
  - Dump shows r3=0xDEADBEEF and r4=0x104 (the frozen write is dropped).
- **Start while busy:** pulse `start` again at word 10.
  - It is ignored: exactly 31 words and a single `done` pulse.
- **Reset mid-dump:** assert `RST` during SEND of word 12.
  - All outputs drop to 0 asynchronously.
  - After release, a new `start` produces a complete dump beginning at addr 1.
- **SKIP_ZERO=0:**
  - The first word is addr 0 with data 0.
  - 32 words are sent; total is 66 cycles.

Source files
------------

// File: rtl/regfile_dump_reader_pkg.sv
// -----------------------------------------------------------------------------
// regfile_dump_reader_pkg
//
// Shared definitions for the register-file debug dump engine:
//   - default geometry of the architectural register file
//   - the dump FSM state enumeration (also exported on the debug state port)
// -----------------------------------------------------------------------------
package regfile_dump_reader_pkg;

   localparam int DEF_NUM_REGS = 32;
   localparam int DEF_ADDR_W   = 5;
   localparam int DEF_DATA_W   = 32;

   // Width of the encoded FSM state as seen on the debug port.
   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      stIdle   = 3'd0,
      stFreeze = 3'd1,
      stFetch  = 3'd2,
      stSend   = 3'd3,
      stDone   = 3'd4
   } dumpState_t;

endpackage : regfile_dump_reader_pkg

// File: rtl/regfile_dump_reader.sv
// -----------------------------------------------------------------------------
// regfile_dump_reader
//
// Debug read-out engine for the CPU register file. A start pulse in IDLE
// freezes architectural writes, then the engine walks the register file's
// second (combinational) read port from the first to the last register and
// streams each (index, value) pair out over a valid/ready link. The freeze is
// released once the last word has been accepted.
//
// Handshake: a word transfers on a rising CLK edge where out_valid and
// out_ready are both high. Once out_valid rises, out_valid, out_addr, out_data
// and out_last hold stable until that transfer; out_valid is never withdrawn
// early. out_ready may be held high continuously.
//
// Ports:
//   CLK, RST    - clock, asynchronous active-high reset
//   start       - dump request, only honoured in IDLE
//   rd_addr     - register file read address (0 when idle)
//   rd_data     - combinational read data for rd_addr
//   freeze      - high for the whole dump; gates the register file WE upstream
//   out_valid   - output word valid
//   out_ready   - consumer accepts the word
//   out_addr    - register index of the output word
//   out_data    - register value of the output word
//   out_last    - marks the word for index NUM_REGS-1
//   busy        - FSM is not in IDLE
//   done        - one-cycle pulse after the final transfer
//   dbgState    - current FSM state encoding, for observation
// -----------------------------------------------------------------------------
module regfile_dump_reader
   import regfile_dump_reader_pkg::*;
#(
   parameter int NUM_REGS  = DEF_NUM_REGS,
   parameter int ADDR_W    = DEF_ADDR_W,    // 2**ADDR_W must be >= NUM_REGS
   parameter int DATA_W    = DEF_DATA_W,
   parameter int SKIP_ZERO = 1              // r0 is hard-wired to 0
)(
   input  logic               CLK,
   input  logic               RST,
   input  logic               start,
   output logic [ADDR_W-1:0]  rd_addr,
   input  logic [DATA_W-1:0]  rd_data,
   output logic               freeze,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ADDR_W-1:0]  out_addr,
   output logic [DATA_W-1:0]  out_data,
   output logic               out_last,
   output logic               busy,
   output logic               done,
   output logic [STATE_W-1:0] dbgState
);

   localparam logic [ADDR_W-1:0] FIRST_IDX = (SKIP_ZERO != 0) ? ADDR_W'(1) : '0;
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

   dumpState_t state;
   dumpState_t stateNext;

   logic [ADDR_W-1:0] idx;
   logic [ADDR_W-1:0] outAddrQ;
   logic [DATA_W-1:0] outDataQ;
   logic              outValidQ;
   logic              outLastQ;

   // Datapath controls decoded by the FSM.
   logic loadIdx;
   logic incIdx;
   logic capture;
   logic clearValid;

   // --------------------------------------------------------------------------
   // FSM state register
   // --------------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= stIdle;
      end else begin
         state <= stateNext;
      end
   end

   // --------------------------------------------------------------------------
   // FSM next-state and combinational outputs
   // --------------------------------------------------------------------------
   always_comb begin
      stateNext  = state;
      rd_addr    = '0;
      freeze     = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      loadIdx    = 1'b0;
      incIdx     = 1'b0;
      capture    = 1'b0;
      clearValid = 1'b0;

      unique case (state)
         stIdle: begin
            if (start) begin
               loadIdx   = 1'b1;
               stateNext = stFreeze;
            end
         end

         // One dead cycle: a write launched in the start cycle lands on the
         // falling edge here, before the first read is sampled.
         stFreeze: begin
            freeze    = 1'b1;
            busy      = 1'b1;
            rd_addr   = idx;
            stateNext = stFetch;
         end

         stFetch: begin
            freeze    = 1'b1;
            busy      = 1'b1;
            rd_addr   = idx;
            capture   = 1'b1;
            stateNext = stSend;
         end

         stSend: begin
            freeze  = 1'b1;
            busy    = 1'b1;
            rd_addr = idx;
            if (outValidQ && out_ready) begin
               clearValid = 1'b1;
               if (outLastQ) begin
                  stateNext = stDone;
               end else begin
                  incIdx    = 1'b1;
                  stateNext = stFetch;
               end
            end
         end

         stDone: begin
            freeze    = 1'b1;
            busy      = 1'b1;
            done      = 1'b1;
            rd_addr   = idx;
            stateNext = stIdle;
         end

         default: begin
            stateNext = stIdle;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Index counter and output word register
   // --------------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         idx       <= '0;
         outAddrQ  <= '0;
         outDataQ  <= '0;
         outValidQ <= 1'b0;
         outLastQ  <= 1'b0;
      end else begin
         if (loadIdx) begin
            idx <= FIRST_IDX;
         end else if (incIdx) begin
            // The walk ends at LAST_IDX, so this never wraps.
            idx <= idx + ADDR_W'(1);
         end

         if (capture) begin
            outDataQ  <= rd_data;
            outAddrQ  <= idx;
            outLastQ  <= (idx == LAST_IDX);
            outValidQ <= 1'b1;
         end else if (clearValid) begin
            outValidQ <= 1'b0;
            outLastQ  <= 1'b0;
         end
      end
   end

   assign out_valid = outValidQ;
   assign out_addr  = outAddrQ;
   assign out_data  = outDataQ;
   assign out_last  = outLastQ;
   assign dbgState  = state;

endmodule : regfile_dump_reader

// File: tb/tb_regfile_dump_reader.sv
// -----------------------------------------------------------------------------
// tb_regfile_dump_reader
//
// Two engines share one register file model: dutA walks from r1, dutB from r0.
// The register file writes on the falling edge; a write launched at a rising
// edge is dropped when freeze was high at that edge.
// -----------------------------------------------------------------------------
module tb_regfile_dump_reader;

   localparam int NR = 32;
   localparam int AW = 5;
   localparam int DW = 32;
   localparam int WW = 1 + AW + DW;   // {last, addr, data}

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic          startA = 1'b0, startB = 1'b0, outReady = 1'b1;
   logic [AW-1:0] rdAddrA, rdAddrB, addrA, addrB;
   logic [DW-1:0] rdDataA, rdDataB, dataA, dataB;
   logic          freezeA, freezeB, validA, validB, lastA, lastB;
   logic          busyA, busyB, doneA, doneB;
   logic [2:0]    stA, stB;

   regfile_dump_reader #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .SKIP_ZERO(1)) dutA (
      .CLK(clk), .RST(rst), .start(startA), .rd_addr(rdAddrA), .rd_data(rdDataA),
      .freeze(freezeA), .out_valid(validA), .out_ready(outReady), .out_addr(addrA),
      .out_data(dataA), .out_last(lastA), .busy(busyA), .done(doneA), .dbgState(stA));

   regfile_dump_reader #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .SKIP_ZERO(0)) dutB (
      .CLK(clk), .RST(rst), .start(startB), .rd_addr(rdAddrB), .rd_data(rdDataB),
      .freeze(freezeB), .out_valid(validB), .out_ready(outReady), .out_addr(addrB),
      .out_data(dataB), .out_last(lastB), .busy(busyB), .done(doneB), .dbgState(stB));

   // ---------------- register file model ----------------
   logic [DW-1:0] regs    [NR];
   logic [DW-1:0] refRegs [NR];   // expected architectural contents
   logic          wrEn = 1'b0;
   logic [AW-1:0] wrAddr = '0;
   logic [DW-1:0] wrData = '0;
   logic          pendValid = 1'b0;
   logic [AW-1:0] pendAddr = '0;
   logic [DW-1:0] pendData = '0;

   assign rdDataA = regs[rdAddrA];
   assign rdDataB = regs[rdAddrB];

   always @(posedge clk) begin
      pendValid <= wrEn && !(freezeA || freezeB);
      pendAddr  <= wrAddr;
      pendData  <= wrData;
   end

   always @(negedge clk) begin
      if (pendValid && pendAddr != '0) regs[pendAddr] = pendData;
   end

   // ---------------- selected-DUT view ----------------
   logic          selB = 1'b0;
   logic          mValid, mLast, mFreeze, mBusy, mDone;
   logic [AW-1:0] mAddr, mRdAddr;
   logic [DW-1:0] mData;
   logic [2:0]    mSt;
   assign mValid  = selB ? validB  : validA;
   assign mLast   = selB ? lastB   : lastA;
   assign mFreeze = selB ? freezeB : freezeA;
   assign mBusy   = selB ? busyB   : busyA;
   assign mDone   = selB ? doneB   : doneA;
   assign mAddr   = selB ? addrB   : addrA;
   assign mRdAddr = selB ? rdAddrB : rdAddrA;
   assign mData   = selB ? dataB   : dataA;
   assign mSt     = selB ? stB     : stA;

   // ---------------- scoreboard ----------------
   logic [WW-1:0] exp_q [$];
   int nCompared = 0;
   int nMismatched = 0;

   task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      nCompared++;
      if (obs !== expv) begin
         nMismatched++;
         $display("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkEq({tag, "_valid"},  {63'd0, mValid},  64'd0);
      checkEq({tag, "_last"},   {63'd0, mLast},   64'd0);
      checkEq({tag, "_addr"},   {59'd0, mAddr},   64'd0);
      checkEq({tag, "_data"},   {32'd0, mData},   64'd0);
      checkEq({tag, "_rdaddr"}, {59'd0, mRdAddr}, 64'd0);
      checkEq({tag, "_freeze"}, {63'd0, mFreeze}, 64'd0);
      checkEq({tag, "_busy"},   {63'd0, mBusy},   64'd0);
      checkEq({tag, "_done"},   {63'd0, mDone},   64'd0);
      checkEq({tag, "_state"},  {61'd0, mSt},     64'd0);
   endtask

   task automatic setReg(input int i, input logic [DW-1:0] v);
      regs[i]    = (i == 0) ? '0 : v;
      refRegs[i] = (i == 0) ? '0 : v;
   endtask

   // ---------------- driver + monitor for one dump ----------------
   // stallAddr/restartAddr/rstAddr < 0 disables that feature.
   task automatic runDump(input bit useB, input int stallAddr, input int stallLen,
                          input int restartAddr, input int rstAddr,
                          input bit randReady, input bit race);
      int nWords, cyc, stallLeft, stallCycles, doneCnt, doneCyc, busyFall;
      bit heldValid, aborted, restarted, finished;
      logic [WW-1:0] held, obsWord;
      logic [WW:0]   expWord;

      selB = useB;
      nWords = useB ? NR : NR - 1;
      exp_q.delete();
      for (int i = (useB ? 0 : 1); i < NR; i++)
         exp_q.push_back({(i == NR - 1), AW'(i), refRegs[i]});

      stallLeft = stallLen; stallCycles = 0; doneCnt = 0; doneCyc = -1; busyFall = -1;
      heldValid = 0; aborted = 0; restarted = 0; finished = 0; held = '0;

      @(negedge clk);
      if (useB) startB = 1'b1; else startA = 1'b1;
      outReady = 1'b1;
      if (race) begin wrEn = 1'b1; wrAddr = 5'd3; wrData = 32'hDEAD_BEEF; end

      for (cyc = 0; cyc < 400 && !finished && !aborted; cyc++) begin
         @(negedge clk);          // observing the cycle after edge 'cyc'
         startA = 1'b0; startB = 1'b0;
         if (race && cyc == 0) begin wrAddr = 5'd4; wrData = 32'h0000_1234; end
         else wrEn = 1'b0;

         obsWord = {mLast, mAddr, mData};
         if (heldValid) begin
            checkEq("stall_valid", {63'd0, mValid}, 64'd1);
            checkEq("stall_word", 64'(obsWord), 64'(held));
         end
         if (mDone) begin
            doneCnt++;
            doneCyc = cyc;
            checkEq("done_freeze", {63'd0, mFreeze}, 64'd1);
         end

         if (!mBusy) begin
            busyFall = cyc;
            checkEq("idle_freeze", {63'd0, mFreeze}, 64'd0);
            finished = 1;
         end else if (mValid) begin
            checkEq("send_freeze", {63'd0, mFreeze}, 64'd1);
            if (rstAddr >= 0 && int'(mAddr) == rstAddr) begin
               #2 rst = 1'b1;
               #1 checkIdleOutputs("async_rst");
               checkEq("rst_no_done", 64'(doneCnt), 64'd0);
               @(negedge clk);
               rst = 1'b0;
               aborted = 1;
               exp_q.delete();
            end else begin
               if (!restarted && restartAddr >= 0 && int'(mAddr) == restartAddr) begin
                  restarted = 1;
                  if (useB) startB = 1'b1; else startA = 1'b1;
               end
               if (stallLeft > 0 && int'(mAddr) == stallAddr) begin
                  outReady = 1'b0;
                  stallLeft--;
               end else begin
                  outReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
               end
               if (outReady) begin
                  heldValid = 0;
                  expWord = (exp_q.size() > 0) ? {1'b1, exp_q.pop_front()} : '0;
                  checkEq("word", 64'({1'b1, obsWord}), 64'(expWord));
               end else begin
                  stallCycles++;
                  heldValid = 1;
                  held = obsWord;
               end
            end
         end else begin
            heldValid = 0;
         end
      end

      outReady = 1'b1;
      wrEn = 1'b0;
      if (!aborted) begin
         checkEq("dump_terminated", {63'd0, mBusy}, 64'd0);
         checkEq("words_left", 64'(exp_q.size()), 64'd0);
         checkEq("done_count", 64'(doneCnt), 64'd1);
         checkEq("done_cycle", 64'(doneCyc), 64'(2 * nWords + 1 + stallCycles));
         checkEq("busy_fall", 64'(busyFall), 64'(2 * nWords + 2 + stallCycles));
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      for (int i = 0; i < NR; i++) setReg(i, 32'h0000_0100 + i);

      // reset state of both engines
      repeat (2) @(negedge clk);
      selB = 1'b0; #1 checkIdleOutputs("reset_a");
      selB = 1'b1; #1 checkIdleOutputs("reset_b");
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // full dump, ready held high
      runDump(1'b0, -1, 0, -1, -1, 1'b0, 1'b0);
      // backpressure on word 7
      runDump(1'b0, 7, 5, -1, -1, 1'b0, 1'b0);
      // write in the start cycle lands; write during freeze is dropped
      refRegs[3] = 32'hDEAD_BEEF;
      runDump(1'b0, -1, 0, -1, -1, 1'b0, 1'b1);
      // start while busy is ignored
      runDump(1'b0, -1, 0, 10, -1, 1'b0, 1'b0);
      // reset mid-dump, then a full dump again
      runDump(1'b0, -1, 0, -1, 12, 1'b0, 1'b0);
      selB = 1'b0; #1 checkIdleOutputs("post_rst");
      runDump(1'b0, -1, 0, -1, -1, 1'b0, 1'b0);
      // walk from r0
      runDump(1'b1, -1, 0, -1, -1, 1'b0, 1'b0);

      // randomized contents and random backpressure on both engines
      for (int k = 0; k < 4; k++) begin
         for (int i = 1; i < NR; i++) setReg(i, $urandom);
         runDump(k[0], -1, 0, -1, -1, 1'b1, 1'b0);
      end

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule : tb_regfile_dump_reader
